// File: rtl/gpio_in_filter_if.sv
// Pad-side signal bundle for the GPIO input filter: raw pins and filter
// controls in, conditioned level and edge pulses out.
interface gpio_in_filter_if #(
  parameter int unsigned PIN_NUM   = 32,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned DIV_WIDTH = 16
);
  logic [PIN_NUM-1:0]   pin_i;
  logic [PIN_NUM-1:0]   en_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic [CNT_WIDTH-1:0] thr_i;
  logic [PIN_NUM-1:0]   filt_o;
  logic [PIN_NUM-1:0]   rise_o;
  logic [PIN_NUM-1:0]   fall_o;

  modport master (
    output pin_i, en_i, div_i, thr_i,
    input  filt_o, rise_o, fall_o
  );

  modport slave (
    input  pin_i, en_i, div_i, thr_i,
    output filt_o, rise_o, fall_o
  );
endinterface

// File: rtl/gpio_in_filter.sv
// Per-pin GPIO input conditioning: 2-flop synchroniser, tick-paced stability
// filter with per-pin bypass, and registered rise/fall pulses.
module gpio_in_filter #(
  parameter int unsigned PIN_NUM   = 32,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  gpio_in_filter_if.slave   bus
);

  logic [PIN_NUM-1:0]   r_sync1;
  logic [PIN_NUM-1:0]   r_sync2;
  logic [PIN_NUM-1:0]   r_filt;
  logic [PIN_NUM-1:0]   r_rise;
  logic [PIN_NUM-1:0]   r_fall;
  logic [DIV_WIDTH-1:0] r_pcnt;
  logic [CNT_WIDTH-1:0] r_cnt [PIN_NUM];

  logic                 w_tick;
  logic [CNT_WIDTH-1:0] w_thr;
  logic [PIN_NUM-1:0]   w_filt_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt [PIN_NUM];

  // >= rather than == so lowering div_i below the running count cannot stall the tick
  always_comb begin
    w_tick = (r_pcnt >= bus.div_i);
    w_thr  = (bus.thr_i == '0) ? CNT_WIDTH'(1) : bus.thr_i;
  end

  always_comb begin
    w_filt_nxt = r_filt;
    for (int unsigned i = 0; i < PIN_NUM; i++) begin
      w_cnt_nxt[i] = '0;
      if (!bus.en_i[i]) begin
        w_filt_nxt[i] = r_sync2[i];
      end else if (r_sync2[i] != r_filt[i]) begin
        if (!w_tick) begin
          w_cnt_nxt[i] = r_cnt[i];
        end else if (({1'b0, r_cnt[i]} + {{CNT_WIDTH{1'b0}}, 1'b1}) >= {1'b0, w_thr}) begin
          w_filt_nxt[i] = r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_filt  <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_pcnt  <= '0;
      for (int unsigned i = 0; i < PIN_NUM; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= bus.pin_i;
      r_sync2 <= r_sync1;
      r_filt  <= w_filt_nxt;
      r_rise  <= w_filt_nxt & ~r_filt;
      r_fall  <= ~w_filt_nxt & r_filt;
      r_pcnt  <= w_tick ? '0 : r_pcnt + 1'b1;
      for (int unsigned i = 0; i < PIN_NUM; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign bus.filt_o = r_filt;
  assign bus.rise_o = r_rise;
  assign bus.fall_o = r_fall;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Randomised and directed bench for gpio_in_filter: a reference model predicts
// filtered levels and edge events; a monitor checks the DUT against them.
module tb_gpio_in_filter;

  localparam int unsigned P = 32;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;

  gpio_in_filter_if #(.PIN_NUM(P), .CNT_WIDTH(8), .DIV_WIDTH(16)) bus ();

  gpio_in_filter #(.PIN_NUM(P), .CNT_WIDTH(8), .DIV_WIDTH(16)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus.slave)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          edge_n;
    logic [31:0] r;
    logic [31:0] f;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] exp_filt = '0;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: a pin's new level is accepted once its synchronised value has
  // disagreed with the filtered level across max(thr,1) ticks, counted on a global tick index.
  initial begin
    int          run_start[P];
    int          tick_total;
    int          since_tick;
    logic [31:0] hist[$];
    logic [31:0] s, nf, rise, fall;
    logic        tick;
    int          n;
    tick_total = 0;
    since_tick = 0;
    hist = '{32'd0, 32'd0};
    for (int i = 0; i < P; i++) run_start[i] = -1;
    forever begin
      @(posedge pclk or negedge presetn);
      if (!presetn) begin
        tick_total = 0;
        since_tick = 0;
        hist = '{32'd0, 32'd0};
        for (int i = 0; i < P; i++) run_start[i] = -1;
        exp_filt = '0;
        exp_q.delete();
      end else begin
        s = hist.pop_front();
        hist.push_back(bus.pin_i);
        tick = (since_tick >= int'(bus.div_i));
        since_tick = tick ? 0 : since_tick + 1;
        n = (bus.thr_i == 0) ? 1 : int'(bus.thr_i);
        nf = exp_filt;
        for (int i = 0; i < P; i++) begin
          if (!bus.en_i[i]) begin
            nf[i] = s[i];
            run_start[i] = -1;
          end else if (s[i] == exp_filt[i]) begin
            run_start[i] = -1;
          end else begin
            if (run_start[i] < 0) run_start[i] = tick_total;
            if (tick && (tick_total - run_start[i] + 1 >= n)) begin
              nf[i] = s[i];
              run_start[i] = -1;
            end
          end
        end
        if (tick) tick_total++;
        rise = nf & ~exp_filt;
        fall = ~nf & exp_filt;
        if ((rise | fall) != 0) exp_q.push_back('{cyc, rise, fall});
        exp_filt = nf;
        cyc++;
      end
    end
  end

  // Monitor: level check every cycle, edge events popped from the scoreboard.
  initial begin
    ev_t ev;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        chk("reset_outputs", {bus.filt_o, bus.rise_o | bus.fall_o}, 64'd0);
      end else begin
        chk("filt_level", bus.filt_o, exp_filt);
        if ((bus.rise_o | bus.fall_o) !== 32'd0) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_edge edge=%0d rise=%0h fall=%0h required=none",
                     cyc - 1, bus.rise_o, bus.fall_o);
          end else begin
            ev = exp_q.pop_front();
            if (ev.edge_n != cyc - 1 || ev.r !== bus.rise_o || ev.f !== bus.fall_o) begin
              failures++;
              $display("FAIL edge_event actual edge=%0d rise=%0h fall=%0h required edge=%0d rise=%0h fall=%0h",
                       cyc - 1, bus.rise_o, bus.fall_o, ev.edge_n, ev.r, ev.f);
            end
          end
        end else begin
          while (exp_q.size() != 0 && exp_q[0].edge_n < cyc - 1) begin
            ev = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_edge actual=none required edge=%0d rise=%0h fall=%0h",
                     ev.edge_n, ev.r, ev.f);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int     n;
    int     len;
    logic   seen;
    bus.pin_i = '0;
    bus.en_i  = '1;
    bus.div_i = '0;
    bus.thr_i = 8'd4;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    repeat (4) @(negedge pclk);

    // 1: thr=4, div=0 -> level on the 6th edge counting the sampling edge
    bus.pin_i[0] = 1'b1;
    repeat (5) @(negedge pclk);
    chk("t1_filt_before", bus.filt_o[0], 1'b0);
    @(negedge pclk);
    chk("t1_filt_after", bus.filt_o[0], 1'b1);
    chk("t1_rise", bus.rise_o[0], 1'b1);
    @(negedge pclk);
    chk("t1_rise_one_cycle", bus.rise_o[0], 1'b0);

    // 2: 3-cycle pulse shorter than thr=4 is rejected
    bus.pin_i[3] = 1'b1;
    repeat (3) @(negedge pclk);
    bus.pin_i[3] = 1'b0;
    repeat (8) @(negedge pclk);
    chk("t2_short_pulse", bus.filt_o[3], 1'b0);

    // 4: bypass passes a 1-cycle glitch 3 edges later
    bus.en_i[7] = 1'b0;
    repeat (2) @(negedge pclk);
    bus.pin_i[7] = 1'b1;
    @(negedge pclk);
    bus.pin_i[7] = 1'b0;
    @(negedge pclk);
    chk("t4_filt_early", bus.filt_o[7], 1'b0);
    @(negedge pclk);
    chk("t4_filt_high", {bus.filt_o[7], bus.rise_o[7]}, 2'b11);
    @(negedge pclk);
    chk("t4_filt_low", {bus.filt_o[7], bus.fall_o[7]}, 2'b01);
    bus.en_i[7] = 1'b1;

    // 5: thr=0 acts as thr=1; lowering div below the running count ticks at once
    bus.thr_i = 8'd0;
    @(negedge pclk);
    bus.pin_i[1] = 1'b1;
    repeat (3) @(negedge pclk);
    chk("t5_thr0", {bus.filt_o[1], bus.rise_o[1]}, 2'b11);
    bus.div_i = 16'd100;
    bus.pin_i[1] = 1'b0;
    repeat (50) @(negedge pclk);
    chk("t5_hold_div100", bus.filt_o[1], 1'b1);
    bus.div_i = 16'd2;
    @(negedge pclk);
    chk("t5_div_lowered", {bus.filt_o[1], bus.fall_o[1]}, 2'b01);
    for (int k = 0; k < 6; k++) begin
      bus.pin_i[1] = ~bus.pin_i[1];
      repeat (4 + k) @(negedge pclk);
    end

    // 3: div=9, thr=3, falling edge on the 3rd tick after the change
    bus.div_i = 16'd9;
    bus.thr_i = 8'd3;
    bus.pin_i[5] = 1'b1;
    repeat (60) @(negedge pclk);
    chk("t3_filt_set", bus.filt_o[5], 1'b1);
    bus.pin_i[5] = 1'b0;
    seen = 1'b0;
    n = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge pclk);
      if (bus.fall_o[5]) begin
        seen = 1'b1;
        n = k;
      end
    end
    checks++;
    if (!seen || n < 23 || n > 32) begin
      failures++;
      $display("FAIL t3_fall_latency actual=%0d required=23..32", n);
    end

    // 6: async reset mid-count on every pin
    bus.div_i = 16'd3;
    bus.thr_i = 8'd8;
    bus.pin_i = ~exp_filt;
    repeat (10) @(negedge pclk);
    #2 presetn = 1'b0;
    #1 chk("t6_async_reset", {bus.filt_o, bus.rise_o | bus.fall_o}, 64'd0);
    repeat (2) @(negedge pclk);
    bus.pin_i = '1;
    presetn = 1'b1;
    repeat (3) @(negedge pclk);
    chk("t6_post_reset", {bus.filt_o, bus.rise_o | bus.fall_o}, 64'd0);
    repeat (60) @(negedge pclk);
    chk("t6_settled", bus.filt_o, 32'hFFFF_FFFF);

    // Random phases: mixed enables, thresholds, prescaler rates and sparse toggles
    for (int ph = 0; ph < 30; ph++) begin
      case ($urandom_range(0, 5))
        0, 1:    bus.div_i = 16'd0;
        2:       bus.div_i = 16'd1;
        3:       bus.div_i = 16'd2;
        4:       bus.div_i = 16'd3;
        default: bus.div_i = 16'd9;
      endcase
      bus.thr_i = 8'($urandom_range(0, 5));
      bus.en_i  = $urandom | $urandom;
      len = $urandom_range(100, 400);
      for (int c = 0; c < len; c++) begin
        @(negedge pclk);
        bus.pin_i = bus.pin_i ^ ($urandom & $urandom & $urandom & $urandom);
        if ($urandom_range(0, 99) == 0) bus.thr_i = 8'($urandom_range(0, 5));
        if ($urandom_range(0, 99) == 0) bus.div_i = 16'($urandom_range(0, 4));
        if ($urandom_range(0, 149) == 0) bus.en_i = bus.en_i ^ $urandom;
      end
    end

    repeat (300) @(negedge pclk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
